// File: rtl/hrm_mem_pkg.sv
// Shared definitions for the MMIO data memory.
//   - IO window offsets (input ports, output ports, STATUS)
//   - FSM state and address-region typedefs
//   - BCD lookup table preloaded into RAM after reset
package hrm_mem_pkg;

  localparam int IO_IN_OFS     = 0;
  localparam int IO_OUT_OFS    = 8;
  localparam int IO_STATUS_OFS = 15;
  localparam int LUT_MAX       = 30;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} mem_state_t;

  typedef enum logic [2:0] {RG_RAM, RG_IN, RG_OUT, RG_STAT, RG_NONE} io_region_t;

  // 4-digit BCD table; entries past the table read as 0000.
  function automatic logic [15:0] lut_bcd(input int unsigned idx);
    case (idx)
      0:  return 16'h0000;  1:  return 16'h0008;  2:  return 16'h0017;
      3:  return 16'h0026;  4:  return 16'h0035;  5:  return 16'h0044;
      6:  return 16'h0053;  7:  return 16'h0062;  8:  return 16'h0071;
      9:  return 16'h0080;  10: return 16'h0089;  11: return 16'h0098;
      12: return 16'h0107;  13: return 16'h0116;  14: return 16'h0125;
      15: return 16'h0133;  16: return 16'h0142;  17: return 16'h0151;
      18: return 16'h0160;  19: return 16'h0169;  20: return 16'h0178;
      21: return 16'h0187;  22: return 16'h0196;  23: return 16'h0205;
      24: return 16'h0214;  25: return 16'h0223;  26: return 16'h0232;
      27: return 16'h0241;  28: return 16'h0250;  29: return 16'h0259;
      default: return 16'h0000;
    endcase
  endfunction

  // Byte at preload address ptr: even = low BCD byte, odd = high BCD byte.
  function automatic logic [7:0] lut_byte(input int unsigned ptr);
    logic [15:0] v;
    v = lut_bcd(ptr >> 1);
    return ptr[0] ? v[15:8] : v[7:0];
  endfunction

endpackage

// File: rtl/in_sync.sv
// Two-flop synchronizer with change detect for one input port.
//   CLK, RESET : clock, synchronous active-high reset
//   d          : asynchronous input word
//   q          : synchronized (second-stage) value
//   chg        : q differs from its value one cycle earlier
module in_sync #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          chg
);

  logic [DW-1:0] s1, s2, s3;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q   = s2;
  assign chg = (s2 != s3);

endmodule

// File: rtl/mmio_data_mem.sv
// Data memory with a memory-mapped IO window in the top 16 addresses.
//   CLK, RESET : clock, synchronous active-high reset
//   ADDR/DATA/MW : CPU address, write data, write enable
//   Q          : registered read data (latency 1, 0 after a write cycle)
//   IN_PORTS   : N_IN asynchronous input words, synchronized internally
//   OUT_PORTS  : N_OUT output registers, OUT_STB pulses on each write
//   READY      : LUT preload finished, CPU access enabled
// After reset the RAM is loaded with the BCD LUT, one byte per cycle.
module mmio_data_mem
  import hrm_mem_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int N_IN    = 3,
  parameter int N_OUT   = 4,
  parameter int LUT_LEN = 30
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [AW-1:0]         ADDR,
  input  logic [DW-1:0]         DATA,
  input  logic                  MW,
  output logic [DW-1:0]         Q,
  input  logic [N_IN*DW-1:0]    IN_PORTS,
  output logic [N_OUT*DW-1:0]   OUT_PORTS,
  output logic [N_OUT-1:0]      OUT_STB,
  output logic                  READY
);

  localparam int            IO_BASE  = 2**AW - 16;
  localparam logic [AW-1:0] PTR_LAST = AW'(2*LUT_LEN - 1);

  // FSM
  mem_state_t    state, state_nx;
  logic [AW-1:0] ptr;
  logic          init_wr, run;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT: if (ptr == PTR_LAST) state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  always_comb begin
    init_wr = 1'b0;
    run     = 1'b0;
    case (state)
      ST_INIT: init_wr = 1'b1;
      ST_RUN:  run     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)        ptr <= '0;
    else if (init_wr) ptr <= ptr + 1'b1;
  end

  assign READY = run;

  // Address decode
  logic       is_io;
  logic [3:0] ofs;
  io_region_t rg;
  logic [N_OUT-1:0] out_sel;

  assign is_io = (ADDR >= AW'(IO_BASE));
  assign ofs   = ADDR[3:0];

  always_comb begin
    out_sel = '0;
    for (int k = 0; k < N_OUT; k++) out_sel[k] = (ofs == 4'(IO_OUT_OFS + k));
  end

  always_comb begin
    rg = RG_NONE;
    if (!is_io)                                rg = RG_RAM;
    else if (ofs < 4'(IO_IN_OFS + N_IN))       rg = RG_IN;
    else if (|out_sel)                         rg = RG_OUT;
    else if (ofs == 4'(IO_STATUS_OFS))         rg = RG_STAT;
  end

  // Input synchronizers
  logic [N_IN-1:0][DW-1:0] sync_q;
  logic [N_IN-1:0]         sync_chg;

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    in_sync #(.DW(DW)) u_sync (
      .CLK   (CLK),
      .RESET (RESET),
      .d     (IN_PORTS[k*DW +: DW]),
      .q     (sync_q[k]),
      .chg   (sync_chg[k])
    );
  end

  // Sticky change flags; a new change outranks a same-cycle W1C.
  logic [N_IN-1:0] flags, flag_clr;
  logic            stat_wr;
  logic [DW-1:0]   status;

  assign stat_wr  = MW && (rg == RG_STAT);
  assign flag_clr = {N_IN{stat_wr}} & DATA[N_IN:1];

  always_ff @(posedge CLK) begin
    if (RESET) flags <= '0;
    else       flags <= sync_chg | (flags & ~flag_clr);
  end

  always_comb begin
    status         = '0;
    status[0]      = run;
    status[N_IN:1] = flags;
  end

  // Output ports
  logic [N_OUT-1:0][DW-1:0] out_r;
  logic [N_OUT-1:0]         stb_r;
  logic                     out_wr;

  assign out_wr = MW && run && (rg == RG_OUT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_r <= '0;
      stb_r <= '0;
    end else begin
      stb_r <= out_sel & {N_OUT{out_wr}};
      for (int k = 0; k < N_OUT; k++)
        if (out_wr && out_sel[k]) out_r[k] <= DATA;
    end
  end

  assign OUT_PORTS = out_r;
  assign OUT_STB   = stb_r;

  // RAM: preload owns the write port during INIT. No reset on contents.
  logic [DW-1:0] ram [IO_BASE];
  logic          ram_we;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [DW-1:0] ram_wd;

  always_comb begin
    if (init_wr) begin
      ram_we = !RESET;
      ram_wa = ptr;
      ram_wd = DW'(lut_byte(int'(ptr)));
    end else begin
      ram_we = !RESET && MW && (rg == RG_RAM);
      ram_wa = ADDR;
      ram_wd = DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  assign ram_ra = is_io ? '0 : ADDR;

  // Read mux; Q register gives the single cycle of latency and sees
  // pre-edge RAM contents, so read-during-write returns old data.
  logic [DW-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (rg)
      RG_RAM:  if (run) rd_mux = ram[ram_ra];
      RG_IN:   if (run) for (int k = 0; k < N_IN; k++)
                 if (ofs == 4'(IO_IN_OFS + k)) rd_mux = sync_q[k];
      RG_OUT:  if (run) for (int k = 0; k < N_OUT; k++)
                 if (out_sel[k]) rd_mux = out_r[k];
      RG_STAT: rd_mux = status;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || MW) Q <= '0;
    else             Q <= rd_mux;
  end

endmodule

// File: tb/tb_mmio_data_mem.sv
module tb_mmio_data_mem;

  localparam int DW = 8, AW = 8, N_IN = 3, N_OUT = 4, LUT_LEN = 30;
  localparam int IO_BASE = 2**AW - 16;
  localparam int PRE = 2*LUT_LEN;

  logic                CLK = 1'b0;
  logic                RESET, MW;
  logic [AW-1:0]       ADDR;
  logic [DW-1:0]       DATA, Q;
  logic [N_IN*DW-1:0]  IN_PORTS;
  logic [N_OUT*DW-1:0] OUT_PORTS;
  logic [N_OUT-1:0]    OUT_STB;
  logic                READY;

  always #5 CLK = ~CLK;

  mmio_data_mem #(.DW(DW), .AW(AW), .N_IN(N_IN), .N_OUT(N_OUT), .LUT_LEN(LUT_LEN)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DATA(DATA), .MW(MW), .Q(Q),
    .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS), .OUT_STB(OUT_STB), .READY(READY)
  );

  typedef struct {
    int                  cyc;
    bit                  q_chk;
    logic [DW-1:0]       q;
    logic [N_OUT-1:0]    stb;
    logic [N_OUT*DW-1:0] outp;
    logic                rdy;
    string               tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: BCD table, RAM image with known flags, sticky flags,
  // input history (reads see the value applied two edges earlier).
  logic [15:0] lut [LUT_LEN] = '{
    16'h0000, 16'h0008, 16'h0017, 16'h0026, 16'h0035, 16'h0044, 16'h0053, 16'h0062,
    16'h0071, 16'h0080, 16'h0089, 16'h0098, 16'h0107, 16'h0116, 16'h0125, 16'h0133,
    16'h0142, 16'h0151, 16'h0160, 16'h0169, 16'h0178, 16'h0187, 16'h0196, 16'h0205,
    16'h0214, 16'h0223, 16'h0232, 16'h0241, 16'h0250, 16'h0259};
  logic [DW-1:0]      ram_m [IO_BASE];
  bit                 ram_k [IO_BASE];
  logic [DW-1:0]      outp_m [N_OUT];
  bit [N_IN-1:0]      flg_m;
  int                 n_run;
  logic [N_IN*DW-1:0] h [3];
  logic [N_IN*DW-1:0] cur_in;

  task automatic model_reset();
    logic [15:0] v;
    n_run = 0;
    flg_m = '0;
    for (int k = 0; k < N_OUT; k++) outp_m[k] = '0;
    for (int k = 0; k < 3; k++) h[k] = '0;
    for (int i = 0; i < PRE; i++) begin
      v = lut[i/2];
      ram_m[i] = (i % 2 == 1) ? v[15:8] : v[7:0];
      ram_k[i] = 1'b1;
    end
  endtask

  task automatic step(input bit rst, input int a, input logic [DW-1:0] d, input bit w,
                      input string tag);
    exp_t e;
    bit   rdy;
    int   o;
    RESET = rst; ADDR = AW'(a); DATA = d; MW = w; IN_PORTS = cur_in;
    e.cyc = cyc + 1; e.tag = tag; e.q_chk = 1'b1; e.q = '0; e.stb = '0;
    o = (a >= IO_BASE) ? a - IO_BASE : -1;
    if (rst) begin
      model_reset();
      e.rdy = 1'b0;
    end else begin
      rdy = (n_run >= PRE);
      if (!w) begin
        if (o < 0) begin
          if (rdy) begin e.q_chk = ram_k[a]; e.q = ram_m[a]; end
        end else if (o == 15) e.q[N_IN:0] = {flg_m, rdy};
        else if (rdy && o < N_IN) e.q = h[1][o*DW +: DW];
        else if (rdy && o >= 8 && o < 8 + N_OUT) e.q = outp_m[o-8];
      end
      if (w && rdy && o < 0) begin ram_m[a] = d; ram_k[a] = 1'b1; end
      if (w && rdy && o >= 8 && o < 8 + N_OUT) begin outp_m[o-8] = d; e.stb[o-8] = 1'b1; end
      if (w && o == 15) flg_m = flg_m & ~d[N_IN:1];
      for (int k = 0; k < N_IN; k++)
        if (h[1][k*DW +: DW] != h[2][k*DW +: DW]) flg_m[k] = 1'b1;
      h[2] = h[1]; h[1] = h[0]; h[0] = cur_in;
      n_run++;
      e.rdy = (n_run >= PRE);
    end
    for (int k = 0; k < N_OUT; k++) e.outp[k*DW +: DW] = outp_m[k];
    sb.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic rd(input int a, input string tag); step(1'b0, a, '0, 1'b0, tag); endtask
  task automatic wr(input int a, input logic [DW-1:0] d, input string tag); step(1'b0, a, d, 1'b1, tag); endtask

  // Monitor: every cycle the DUT presents Q/OUT/READY; compare against queue.
  exp_t me;
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      me = sb.pop_front();
      errors++; checks++;
      $display("FAIL stale_%s: expected item for cycle %0d never compared (now %0d)", me.tag, me.cyc, cyc);
    end
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      me = sb.pop_front();
      if (me.q_chk) begin
        checks++;
        if (Q !== me.q) begin errors++; $display("FAIL q_%s cyc=%0d: got %h want %h", me.tag, cyc, Q, me.q); end
      end
      checks++;
      if (OUT_STB !== me.stb) begin errors++; $display("FAIL stb_%s cyc=%0d: got %b want %b", me.tag, cyc, OUT_STB, me.stb); end
      checks++;
      if (OUT_PORTS !== me.outp) begin errors++; $display("FAIL outp_%s cyc=%0d: got %h want %h", me.tag, cyc, OUT_PORTS, me.outp); end
      checks++;
      if (READY !== me.rdy) begin errors++; $display("FAIL ready_%s cyc=%0d: got %b want %b", me.tag, cyc, READY, me.rdy); end
    end
  end

  localparam int STAT = IO_BASE + 15;

  initial begin
    int r, a;
    RESET = 1'b1; MW = 1'b0; ADDR = '0; DATA = '0; IN_PORTS = '0; cur_in = '0;
    for (int i = 0; i < IO_BASE; i++) begin ram_m[i] = '0; ram_k[i] = 1'b0; end
    @(posedge CLK); #1;
    step(1'b1, 0, '0, 1'b0, "rst");
    step(1'b1, 0, '0, 1'b0, "rst");

    // INIT: CPU writes ignored, Q 0 except STATUS
    rd(30, "init_rd");
    wr(10, 8'hA5, "init_wr_ram");
    wr(IO_BASE + 9, 8'h77, "init_wr_out");
    rd(STAT, "init_stat");
    rd(IO_BASE + 9, "init_rd_out");
    while (n_run < PRE + 2) rd(STAT, "preload");

    rd(30, "lut30"); rd(31, "lut31"); rd(58, "lut58"); rd(59, "lut59");
    rd(10, "lut10_ignored");
    rd(0, "lut0");

    wr(IO_BASE + 9, 8'h3C, "out1_wr");
    rd(IO_BASE + 9, "out1_rd");
    wr(IO_BASE + 8, 8'h11, "out0_wr");
    wr(IO_BASE + 11, 8'h22, "out3_wr");
    rd(IO_BASE + 11, "out3_rd");

    // RAM write + read-back, then write-cycle Q=0
    wr(100, 8'hC3, "ram_wr");
    rd(100, "ram_rd");

    // input 0 change 0x00 -> 0x7E
    cur_in[7:0] = 8'h7E;
    rd(IO_BASE, "in0_a"); rd(IO_BASE, "in0_b"); rd(IO_BASE, "in0_c");
    rd(STAT, "stat_set");
    wr(STAT, 8'h02, "stat_w1c");
    rd(STAT, "stat_clr");

    // W1C lands on the same edge a new change sets the flag
    cur_in[7:0] = 8'h11;
    rd(STAT, "race_a"); rd(STAT, "race_b");
    wr(STAT, 8'h02, "race_w1c");
    rd(STAT, "race_rd");
    rd(STAT, "race_rd2");

    // reset in the middle of INIT restarts preload
    step(1'b1, 0, '0, 1'b0, "rst2");
    for (int i = 0; i < 20; i++) rd(STAT, "init2");
    step(1'b1, 0, '0, 1'b0, "rst3");
    for (int i = 0; i < PRE + 3; i++) rd(STAT, "preload2");
    rd(100, "ram_kept");
    rd(58, "lut58_b");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) cur_in = N_IN*DW'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3)      a = $urandom_range(0, 63);
      else if (r < 5) a = $urandom_range(0, IO_BASE - 1);
      else            a = IO_BASE + $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) wr(a, DW'($urandom), "rnd_wr");
      else                           rd(a, "rnd_rd");
    end
    rd(STAT, "tail"); rd(STAT, "tail");

    @(negedge CLK); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected items left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
